// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: size encodings, entry layout and the
// alignment rule shared by the datapath.
package store_unit_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int BE_W    = 4;
  localparam int ENTRY_W = 32 + 32 + BE_W;

  typedef struct packed {
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [BE_W-1:0] be;
  } store_entry_t;

  // Size 11 is reserved and never aligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lo[0];
      SIZE_WORD: return lo == 2'b00;
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/store_unit_if.sv
// CPU-side store request and memory-side write channel of the store unit.
interface store_unit_if #(parameter int DEPTH = 2);
  import store_unit_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic            inValid;
  logic            inReady;
  logic [31:0]     addr;
  logic [31:0]     din;
  logic [1:0]      size;
  logic            misalign;
  logic            memValid;
  logic            memReady;
  logic [31:0]     memAddr;
  logic [31:0]     memData;
  logic [BE_W-1:0] memBe;
  logic [CNT_W-1:0] pending;

  modport slave (
    input  inValid, addr, din, size, memReady,
    output inReady, misalign, memValid, memAddr, memData, memBe, pending
  );

  modport master (
    output inValid, addr, din, size, memReady,
    input  inReady, misalign, memValid, memAddr, memData, memBe, pending
  );
endinterface

// File: rtl/store_fifo.sv
// Store buffer: power-of-two FIFO with registered not-full ready so a dequeue
// never frees a slot for an enqueue in the same cycle.
module store_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 68,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count_nxt;
  logic          push, pop;

  assign out_valid = count != '0;
  assign out_data  = mem[rptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count    <= count_nxt;
      in_ready <= count_nxt < CW'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end
endmodule

// File: rtl/store_unit.sv
// Store unit: checks alignment, formats byte/half/word stores into a
// lane-replicated word write with byte enables, and buffers them in order.
module store_unit import store_unit_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  store_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  aligned;
  logic [BE_W-1:0][7:0]  lane_data;
  logic [BE_W-1:0]       be;
  store_entry_t          enq, deq;
  logic                  deq_valid;
  logic [CW-1:0]         count;

  assign aligned = is_aligned(bus.size, bus.addr[1:0]);

  // Each byte lane picks its source byte from the store size.
  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign lane_data[i] = (bus.size == SIZE_WORD) ? bus.din[8*i +: 8] :
                          (bus.size == SIZE_HALF) ? bus.din[8*(i%2) +: 8] :
                                                    bus.din[7:0];
  end

  always_comb begin
    case (bus.size)
      SIZE_BYTE: be = 4'b0001 << bus.addr[1:0];
      SIZE_HALF: be = bus.addr[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
  end

  assign enq.addr = {bus.addr[31:2], 2'b00};
  assign enq.data = lane_data;
  assign enq.be   = be;

  store_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.inValid & aligned),
    .in_ready  (bus.inReady),
    .in_data   (enq),
    .out_valid (deq_valid),
    .out_ready (bus.memReady),
    .out_data  (deq),
    .count     (count)
  );

  // Outputs forced to zero when empty, which also covers the reset window.
  assign bus.memValid = deq_valid;
  assign bus.memAddr  = deq_valid ? deq.addr : '0;
  assign bus.memData  = deq_valid ? deq.data : '0;
  assign bus.memBe    = deq_valid ? deq.be   : '0;
  assign bus.pending  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.misalign <= 1'b0;
    else        bus.misalign <= bus.inValid & bus.inReady & ~aligned;
  end
endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_store_unit;
  import store_unit_pkg::*;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_unit_if #(.DEPTH(DEPTH)) bus ();
  store_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t        q[$];
  logic [31:0] emitted[$];
  logic        m_mis = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit aligned_m(input logic [31:0] a, input logic [1:0] s);
    int nb;
    if (s == 2'd3) return 1'b0;
    nb = 1 << s;
    return (a % 32'(nb)) == 0;
  endfunction

  function automatic exp_t fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    exp_t e;
    e.a = a & ~32'h3;
    if (s == 2'd0) begin
      e.d  = {24'h0, d[7:0]} * 32'h01010101;
      e.be = 4'(1 << (a % 4));
    end else if (s == 2'd1) begin
      e.d  = {16'h0, d[15:0]} * 32'h00010001;
      e.be = (a & 32'h2) != 0 ? 4'hC : 4'h3;
    end else begin
      e.d  = d;
      e.be = 4'hF;
    end
    return e;
  endfunction

  // Compare against the model, then advance the model by the coming edge.
  always @(negedge clk) begin
    bit acc, deq, ok;
    if (!rst_n) begin
      q.delete();
      m_mis = 1'b0;
    end
    chk("pending",  32'(bus.pending), 32'(q.size()));
    chk("inReady",  32'(bus.inReady), 32'(q.size() < DEPTH));
    chk("memValid", 32'(bus.memValid), 32'(q.size() != 0));
    chk("misalign", 32'(bus.misalign), 32'(m_mis));
    if (!rst_n) begin
      chk("memAddr_rst", bus.memAddr, 32'h0);
      chk("memData_rst", bus.memData, 32'h0);
      chk("memBe_rst",   32'(bus.memBe), 32'h0);
    end else if (q.size() != 0) begin
      chk("memAddr", bus.memAddr, q[0].a);
      chk("memData", bus.memData, q[0].d);
      chk("memBe",   32'(bus.memBe), 32'(q[0].be));
    end
    if (rst_n) begin
      ok    = aligned_m(bus.addr, bus.size);
      deq   = (q.size() != 0) && bus.memReady;
      acc   = bus.inValid && (q.size() < DEPTH) && ok;
      m_mis = bus.inValid && (q.size() < DEPTH) && !ok;
      if (deq) begin
        emitted.push_back(q[0].d);
        void'(q.pop_front());
      end
      if (acc) q.push_back(fmt(bus.addr, bus.din, bus.size));
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic mr);
    bus.inValid  = v;
    bus.addr     = a;
    bus.din      = d;
    bus.size     = s;
    bus.memReady = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pending",  32'(bus.pending), 32'h0);
    chk("rst_memValid", 32'(bus.memValid), 32'h0);
    chk("rst_inReady",  32'(bus.inReady), 32'h1);
    rst_n = 1'b1;

    // Byte store on the very first edge after reset release.
    drive(1'b1, 32'h1003, 32'h123456AB, 2'd0, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("sb_valid", 32'(bus.memValid), 32'h1);
    chk("sb_addr",  bus.memAddr, 32'h1000);
    chk("sb_data",  bus.memData, 32'hABABABAB);
    chk("sb_be",    32'(bus.memBe), 32'h8);
    step();
    chk("sb_drained", 32'(bus.memValid), 32'h0);

    // Half then word, back to back.
    drive(1'b1, 32'h2002, 32'hFFFFBEEF, 2'd1, 1'b1);
    step();
    chk("sh_data", bus.memData, 32'hBEEFBEEF);
    chk("sh_be",   32'(bus.memBe), 32'hC);
    drive(1'b1, 32'h3000, 32'hDEADBEEF, 2'd2, 1'b1);
    step();
    chk("sw_data", bus.memData, 32'hDEADBEEF);
    chk("sw_be",   32'(bus.memBe), 32'hF);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    step();

    // Three rejected stores in a row.
    drive(1'b1, 32'h2001, 32'h1, 2'd1, 1'b1);
    step();
    chk("mis1", 32'(bus.misalign), 32'h1);
    drive(1'b1, 32'h3002, 32'h2, 2'd2, 1'b1);
    step();
    chk("mis2", 32'(bus.misalign), 32'h1);
    chk("mis2_pending", 32'(bus.pending), 32'h0);
    drive(1'b1, 32'h0, 32'h3, 2'd3, 1'b1);
    step();
    chk("mis3", 32'(bus.misalign), 32'h1);
    chk("mis3_memValid", 32'(bus.memValid), 32'h0);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    chk("mis_end", 32'(bus.misalign), 32'h0);

    // Back-pressure: fill, stall the third, then drain in order.
    emitted.delete();
    drive(1'b1, 32'h4000, 32'h11, 2'd2, 1'b0);
    step();
    drive(1'b1, 32'h4004, 32'h22, 2'd2, 1'b0);
    step();
    chk("full_pending", 32'(bus.pending), 32'h2);
    chk("full_inReady", 32'(bus.inReady), 32'h0);
    drive(1'b1, 32'h4008, 32'h33, 2'd2, 1'b0);
    repeat (3) begin
      step();
      chk("stall_data", bus.memData, 32'h11);
      chk("stall_pending", 32'(bus.pending), 32'h2);
    end
    bus.memReady = 1'b1;
    n = 0;
    while (!bus.inReady && n < 20) begin
      step();
      n++;
    end
    chk("stall_timeout", 32'(n < 20), 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    repeat (4) step();
    chk("order_cnt", 32'(emitted.size()), 32'h3);
    if (emitted.size() == 3) begin
      chk("order_1", emitted[0], 32'h11);
      chk("order_2", emitted[1], 32'h22);
      chk("order_3", emitted[2], 32'h33);
    end

    // Steady state: simultaneous enqueue and dequeue.
    emitted.delete();
    drive(1'b1, 32'h5000, 32'd100, 2'd2, 1'b0);
    step();
    chk("ss_start", 32'(bus.pending), 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h5004 + 32'(4 * i), 32'(101 + i), 2'd2, 1'b1);
      step();
      chk("ss_pending", 32'(bus.pending), 32'h1);
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    repeat (3) step();
    chk("ss_cnt", 32'(emitted.size()), 32'd11);
    for (int i = 0; i < emitted.size() && i < 11; i++)
      chk("ss_order", emitted[i], 32'(100 + i));

    // Reset with two stores buffered.
    drive(1'b1, 32'h6000, 32'hA, 2'd2, 1'b0);
    step();
    drive(1'b1, 32'h6004, 32'hB, 2'd2, 1'b0);
    step();
    chk("pre_rst_pending", 32'(bus.pending), 32'h2);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pending",  32'(bus.pending), 32'h0);
    chk("mid_rst_memValid", 32'(bus.memValid), 32'h0);
    chk("mid_rst_memData",  bus.memData, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'h7002, 32'h1234CAFE, 2'd1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("post_rst_addr", bus.memAddr, 32'h7000);
    chk("post_rst_data", bus.memData, 32'hCAFECAFE);
    chk("post_rst_be",   32'(bus.memBe), 32'hC);
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    repeat (5) step();
    chk("final_empty", 32'(bus.pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
